// File: rtl/ram_stream_reader.sv
// Streams a run of consecutive words out of a single-port Ram onto a valid/ready
// interface, hiding the RAM's one-cycle read latency behind a 2-entry buffer.
module ram_stream_reader #(
    parameter  int WORD_SIZE   = 8,
    parameter  int LENGTH_SIZE = 784,
    localparam int ADR_SIZE    = $clog2(LENGTH_SIZE)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 start,
    input  logic [ADR_SIZE-1:0]  baseAdr,
    input  logic [ADR_SIZE:0]    count,
    output logic                 busy,
    output logic                 done,
    output logic                 ramRd,
    output logic                 ramWr,
    output logic [ADR_SIZE-1:0]  ramAdr,
    input  logic [WORD_SIZE-1:0] ramDataOut,
    output logic [WORD_SIZE-1:0] outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 outLast
);

    localparam logic [ADR_SIZE-1:0] ADR_LAST = ADR_SIZE'(LENGTH_SIZE - 1);
    localparam logic [ADR_SIZE-1:0] ADR_ONE  = ADR_SIZE'(1);
    localparam logic [ADR_SIZE:0]   CNT_ONE  = (ADR_SIZE + 1)'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [ADR_SIZE:0]    cnt_q, issued_q, popped_q;
    logic [ADR_SIZE-1:0]  adr_q;
    logic                 vld_p1;
    logic [1:0]           fill_q;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [WORD_SIZE-1:0] fifo_q [2];
    logic [2:0]           occ;
    logic                 pop, fifo_wr, fifo_rd, done_nxt, last_issue, last_pop;

    // The word returning from the RAM counts as buffer occupancy in the cycle it
    // arrives, so an empty buffer forwards it directly and the stream has no bubble.
    assign outValid = (fill_q != 2'd0) || vld_p1;
    assign outData  = (fill_q != 2'd0) ? fifo_q[rd_ptr_q]
                    : (vld_p1 ? ramDataOut : '0);
    assign pop      = outValid && outReady;
    assign outLast  = outValid && (popped_q + CNT_ONE == cnt_q);

    assign occ      = {1'b0, fill_q} + {2'b00, vld_p1} - {2'b00, pop};
    assign ramRd    = (state == READ) && (issued_q < cnt_q) && (occ < 3'd2);
    assign ramWr    = 1'b0;
    assign ramAdr   = adr_q;
    assign busy     = (state != IDLE);

    assign fifo_wr    = vld_p1 && !(pop && fill_q == 2'd0);
    assign fifo_rd    = pop && (fill_q != 2'd0);
    assign last_issue = ramRd && (issued_q + CNT_ONE == cnt_q);
    assign last_pop   = pop && (popped_q + CNT_ONE == cnt_q);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) done_nxt = 1'b1;
                    else             state_nxt = READ;
                end
            end
            READ: begin
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0 -> p1: read issue, address walk and buffer bookkeeping
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            done     <= 1'b0;
            cnt_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            adr_q    <= '0;
            vld_p1   <= 1'b0;
            fill_q   <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done   <= done_nxt;
            vld_p1 <= ramRd;
            if (state == IDLE && start) begin
                cnt_q    <= count;
                adr_q    <= baseAdr;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (ramRd) begin
                    issued_q <= issued_q + CNT_ONE;
                    adr_q    <= (adr_q == ADR_LAST) ? '0 : adr_q + ADR_ONE;
                end
                if (pop) popped_q <= popped_q + CNT_ONE;
            end
            if (fifo_wr) wr_ptr_q <= !wr_ptr_q;
            if (fifo_rd) rd_ptr_q <= !rd_ptr_q;
            fill_q <= fill_q + {1'b0, fifo_wr} - {1'b0, fifo_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_q[wr_ptr_q] <= ramDataOut;
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rstN)
        !(fifo_wr && !fifo_rd && fill_q == 2'd2));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a behavioural Ram, expected addresses and
// words queued at each start, compared as reads are issued and words are handed off.
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  baseAdr = '0;
    logic [10:0] count = '0;
    logic        busy, done, ramRd, ramWr, outValid, outLast;
    logic        outReady = 1'b1;
    logic [9:0]  ramAdr;
    logic [7:0]  ramDataOut = '0;
    logic [7:0]  outData;

    ram_stream_reader #(.WORD_SIZE(8), .LENGTH_SIZE(784)) dut (
        .clk(clk), .rstN(rstN), .start(start), .baseAdr(baseAdr), .count(count),
        .busy(busy), .done(done), .ramRd(ramRd), .ramWr(ramWr), .ramAdr(ramAdr),
        .ramDataOut(ramDataOut), .outData(outData), .outValid(outValid),
        .outReady(outReady), .outLast(outLast)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_mem [784];
    initial for (int i = 0; i < 784; i++) ram_mem[i] = 8'(i);
    always @(posedge clk) if (ramRd) ramDataOut <= ram_mem[ramAdr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int exp_adr[$];
    int exp_data[$];
    int exp_last[$];
    int t0 = 0, done_rel = -1, first_hs = -1, hs_cnt = 0, rd_seen = 0, busy_seen = 0;
    int outstanding = 0;
    bit hold_pend = 1'b0;
    logic [7:0] hold_d;
    logic hold_l;
    bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    initial forever begin
        int rel;
        bit pop_now;
        @(negedge clk);
        if (rstN) begin
            rel = cyc + 1 - t0;
            pop_now = outValid && outReady;
            if (busy) busy_seen = 1;
            if (done) begin
                if (done_rel < 0) done_rel = rel;
                check_val("busy_at_done", int'(busy), 0);
            end
            if (hold_pend) begin
                check_val("hold_vld", int'(outValid), 1);
                check_val("hold_data", int'(outData), int'(hold_d));
                check_val("hold_last", int'(outLast), int'(hold_l));
            end
            if (ramRd) begin
                rd_seen++;
                check_val("rd_space", int'((outstanding - int'(pop_now)) < 2), 1);
                if (exp_adr.size() == 0) check_val("rd_extra", 1, 0);
                else check_val("rd_adr", int'(ramAdr), exp_adr.pop_front());
            end
            if (pop_now) begin
                if (hs_cnt == 0) first_hs = rel;
                hs_cnt++;
                if (exp_data.size() == 0) check_val("hs_extra", 1, 0);
                else begin
                    check_val("data", int'(outData), exp_data.pop_front());
                    check_val("last", int'(outLast), exp_last.pop_front());
                end
            end
            hold_pend = outValid && !outReady;
            hold_d = outData;
            hold_l = outLast;
            outstanding = outstanding + int'(ramRd) - int'(pop_now);
        end
    end

    task automatic push_exp(input int base, input int cnt);
        int a;
        for (int i = 0; i < cnt; i++) begin
            a = (base + i) % 784;
            exp_adr.push_back(a);
            exp_data.push_back(a % 256);
            exp_last.push_back(int'(i == cnt - 1));
        end
    endtask

    task automatic run(input int base, input int cnt, input bit bp, input int spur_at);
        done_rel = -1; first_hs = -1; hs_cnt = 0; rd_seen = 0; busy_seen = 0;
        push_exp(base, cnt);
        @(posedge clk); #2;
        start = 1'b1; baseAdr = 10'(base); count = 11'(cnt); t0 = cyc + 1;
        for (int k = 0; k < cnt * 4 + 20 && done_rel < 0; k++) begin
            @(posedge clk); #2;
            start = (k == spur_at);
            if (k == spur_at) begin baseAdr = 10'd300; count = 11'd2; end
            outReady = bp ? pat[k % 8] : 1'b1;
        end
        start = 1'b0; outReady = 1'b1;
        if (done_rel < 0) check_val("timeout", 0, 1);
        check_val("words", hs_cnt, cnt);
        check_val("sb_data_left", exp_data.size(), 0);
        check_val("sb_adr_left", exp_adr.size(), 0);
        if (cnt == 0) begin
            check_val("zero_done_rel", done_rel, 1);
            check_val("zero_busy", busy_seen, 0);
            check_val("zero_reads", rd_seen, 0);
        end else if (!bp) begin
            check_val("first_hs_rel", first_hs, 2);
            check_val("done_rel", done_rel, cnt + 2);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_rd"}, int'(ramRd), 0);
        check_val({tag, "_wr"}, int'(ramWr), 0);
        check_val({tag, "_adr"}, int'(ramAdr), 0);
        check_val({tag, "_vld"}, int'(outValid), 0);
        check_val({tag, "_last"}, int'(outLast), 0);
        check_val({tag, "_data"}, int'(outData), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #1;
        check_reset_outputs("rst0");
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;

        run(10, 5, 1'b0, -1);      // basic
        run(20, 6, 1'b1, -1);      // backpressure
        run(700, 11, 1'b1, -1);    // longer backpressure pattern
        run(782, 4, 1'b0, -1);     // address wrap
        run(5, 0, 1'b0, -1);       // zero length
        run(0, 784, 1'b0, -1);     // full length
        run(50, 8, 1'b0, 3);       // start while busy is ignored

        // Abort a run with two words buffered and the consumer stalled.
        push_exp(100, 20);
        @(posedge clk); #2;
        outReady = 1'b0; start = 1'b1; baseAdr = 10'd100; count = 11'd20; t0 = cyc + 1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_val("pre_rst_vld", int'(outValid), 1);
        check_val("pre_rst_busy", int'(busy), 1);
        check_val("pre_rst_rd", int'(ramRd), 0);
        rstN = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_adr.delete(); exp_data.delete(); exp_last.delete();
        outstanding = 0; hold_pend = 1'b0;
        @(posedge clk); #2;
        check_reset_outputs("rst_hold");
        rstN = 1'b1; outReady = 1'b1;
        run(0, 3, 1'b0, -1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
